// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with byte-masked writes, pending-write scoreboard and post-reset zeroing.
// Define RF_BYPASS_EN to forward same-cycle writeback data (byte-merged) to the read ports.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NR = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NR*ADDR_W-1:0]  raddr,
  output logic [NR*DATA_W-1:0]  rdata,
  output logic [NR-1:0]         rbusy,
  input  logic                  set_valid,
  input  logic [ADDR_W-1:0]     set_addr,
  input  logic                  wen,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W/8-1:0]   wbytes,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  ready,
  output logic [DATA_W/8-1:0]   debug_wb_rf_wen,
  output logic [ADDR_W-1:0]     debug_wb_rf_wnum,
  output logic [DATA_W-1:0]     debug_wb_rf_wdata
);
  localparam int NB = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [ADDR_W-1:0] cnt;
  logic [DEPTH-1:0] busy, busy_nxt;
  logic [DATA_W-1:0] rf [DEPTH];
  logic [DATA_W-1:0] wmask;
  logic commit;
  assign commit = ready && wen && waddr != '0;
  for (genvar k = 0; k < NB; k++) begin : g_mask
    assign wmask[k*8 +: 8] = {8{wbytes[k]}};
  end
  // Set after clear so a same-edge issue of the same destination keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (commit) busy_nxt[waddr] = 1'b0;
    if (set_valid && set_addr != '0) busy_nxt[set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= INIT;
      cnt <= ADDR_W'(1);
      ready <= 1'b0;
      busy <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + ADDR_W'(1);
      if (&cnt) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end else begin
      busy <= busy_nxt;
    end
  always_ff @(posedge clk)
    if (state == INIT) rf[cnt] <= '0;
    else if (commit) rf[waddr] <= (rf[waddr] & ~wmask) | (wdata & wmask);
  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic hit;
    logic [DATA_W-1:0] q;
    assign a = raddr[i*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
    assign hit = commit && waddr == a;
    assign q = hit ? (rf[a] & ~wmask) | (wdata & wmask) : rf[a];
`else
    assign hit = 1'b0;
    assign q = rf[a];
`endif
    assign rdata[i*DATA_W +: DATA_W] = (ready && a != '0) ? q : '0;
    assign rbusy[i] = ready && busy[a] && !hit;
  end
  assign debug_wb_rf_wen = commit ? wbytes : '0;
  assign debug_wb_rf_wnum = waddr;
  assign debug_wb_rf_wdata = wdata;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NB = DW / 8;
  localparam int DEPTH = 1 << AW;
  typedef struct {
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0] rbusy;
    logic ready;
    logic [NB-1:0] dwen;
    logic [AW-1:0] dwnum;
    logic [DW-1:0] dwdata;
  } exp_t;
  logic clk = 1'b0;
  logic resetn;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0] rbusy;
  logic set_valid;
  logic [AW-1:0] set_addr;
  logic wen;
  logic [AW-1:0] waddr;
  logic [NB-1:0] wbytes;
  logic [DW-1:0] wdata;
  logic ready;
  logic [NB-1:0] debug_wb_rf_wen;
  logic [AW-1:0] debug_wb_rf_wnum;
  logic [DW-1:0] debug_wb_rf_wdata;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [DW-1:0] mem [DEPTH];
  bit mbusy [DEPTH];
  bit mready;
  int medges;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NR(NR)) dut (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .set_valid(set_valid), .set_addr(set_addr), .wen(wen), .waddr(waddr),
    .wbytes(wbytes), .wdata(wdata), .ready(ready),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [NB-1:0] be);
    logic [DW-1:0] o;
    o = old;
    for (int k = 0; k < NB; k++)
      if (be[k]) o[k*8 +: 8] = nw[k*8 +: 8];
    return o;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    bit hit;
    for (int p = 0; p < NR; p++) begin
      a = raddr[p*AW +: AW];
      hit = 0;
`ifdef RF_BYPASS_EN
      hit = mready && wen && waddr == a && waddr != 0;
`endif
      v = hit ? merge(mem[a], wdata, wbytes) : mem[a];
      e.rdata[p*DW +: DW] = (mready && a != 0) ? v : '0;
      e.rbusy[p] = mready && a != 0 && mbusy[a] && !hit;
    end
    e.ready = mready;
    e.dwen = (mready && wen && waddr != 0) ? wbytes : '0;
    e.dwnum = waddr;
    e.dwdata = wdata;
    return e;
  endfunction

  task automatic model_reset();
    mready = 0;
    medges = 0;
    for (int r = 0; r < DEPTH; r++) begin
      mem[r] = '0;
      mbusy[r] = 0;
    end
  endtask

  task automatic model_edge();
    if (!resetn) return;
    if (!mready) begin
      medges++;
      if (medges == DEPTH - 1) mready = 1;
      return;
    end
    if (wen && waddr != 0) begin
      mem[waddr] = merge(mem[waddr], wdata, wbytes);
      mbusy[waddr] = 0;
    end
    if (set_valid && set_addr != 0) mbusy[set_addr] = 1;
  endtask

  task automatic step();
    if (!resetn) model_reset();
    q.push_back(expect_now());
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic drive(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic sv,
                       input logic [AW-1:0] sa, input logic we, input logic [AW-1:0] wa,
                       input logic [NB-1:0] wb, input logic [DW-1:0] wd);
    raddr = {a1, a0};
    set_valid = sv;
    set_addr = sa;
    wen = we;
    waddr = wa;
    wbytes = wb;
    wdata = wd;
    step();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ready", 64'(ready), 64'(e.ready));
      chk("rdata0", 64'(rdata[DW-1:0]), 64'(e.rdata[DW-1:0]));
      chk("rdata1", 64'(rdata[2*DW-1:DW]), 64'(e.rdata[2*DW-1:DW]));
      chk("rbusy", 64'(rbusy), 64'(e.rbusy));
      chk("dbg_wen", 64'(debug_wb_rf_wen), 64'(e.dwen));
      chk("dbg_wnum", 64'(debug_wb_rf_wnum), 64'(e.dwnum));
      chk("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(e.dwdata));
    end

  initial begin
    resetn = 1'b0;
    raddr = '0;
    set_valid = 1'b0;
    set_addr = '0;
    wen = 1'b0;
    waddr = '0;
    wbytes = '0;
    wdata = '0;
    model_reset();
    @(posedge clk);
    #1;
    repeat (3) drive(5'd1, 5'd31, 0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    // writes and issues during init must be ignored
    for (int i = 0; i < 34; i++)
      drive(5'd9, 5'(i), i < 31, 5'd9, i < 31, 5'd9, 4'hF, 32'hA5A5A5A5);
    for (int a = 0; a < DEPTH; a++)
      drive(5'(a), 5'(DEPTH - 1 - a), 0, 0, 0, 0, 0, 0);
    drive(5'd5, 5'd0, 0, 0, 1, 5'd5, 4'hF, 32'hDEADBEEF);
    drive(5'd5, 5'd5, 0, 0, 1, 5'd5, 4'b0010, 32'h00001200);
    drive(5'd5, 5'd0, 0, 0, 0, 0, 0, 0);
    drive(5'd0, 5'd5, 1, 5'd0, 1, 5'd0, 4'hF, 32'hFFFFFFFF);
    drive(5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    drive(5'd7, 5'd0, 1, 5'd7, 0, 0, 0, 0);
    drive(5'd7, 5'd0, 1, 5'd7, 1, 5'd7, 4'hF, 32'h12345678);
    drive(5'd7, 5'd0, 0, 0, 1, 5'd7, 4'hF, 32'h0BADF00D);
    drive(5'd7, 5'd0, 0, 0, 0, 0, 0, 0);
    drive(5'd3, 5'd0, 1, 5'd3, 1, 5'd3, 4'hF, 32'h11223344);
    drive(5'd3, 5'd3, 0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    repeat (2) drive(5'd3, 5'd3, 0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    repeat (33) drive(5'd3, 5'd0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 2000; n++) begin
      resetn = ($urandom_range(0, 299) != 0);
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom_range(0, 2) == 0,
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)), $urandom);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
